// File: rtl/tdc_readout_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_readout_ctrl
// Host-side sequencer for the tdc measurement core. A start request fires an
// activate/deactivate pulse pair separated by a programmable gap and waits for
// the core to settle. It then walks out_sel over every output byte to assemble
// the measurement word, and finally offers that word on a valid/ready
// handshake. All outputs come straight from registers.
// -----------------------------------------------------------------------------
module tdc_readout_ctrl #(
    parameter int NUM_BYTES     = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int READ_WAIT     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             delay_cfg,
    input  logic [2:0]             bit_sel_cfg,
    output logic                   ro_activate,
    output logic                   ro_deactivate,
    output logic [2:0]             bit_sel,
    output logic [2:0]             out_sel,
    input  logic [7:0]             tdc_byte,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   busy
);

    // The shared counter serves both the GAP phase (up to 255) and the SETTLE
    // phase, so it is at least 8 bits and grows if SETTLE_CYCLES is large.
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W  = (SET_W > 8) ? SET_W : 8;
    localparam int WAIT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_W'(READ_WAIT);
    localparam logic [2:0]        LAST_BYTE   = 3'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_GAP    = 3'd2,
        S_STOP   = 3'd3,
        S_SETTLE = 3'd4,
        S_READ   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                   state_q;
    logic [7:0]               delay_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [WAIT_W-1:0]        wait_q;
    logic                     act_q;
    logic                     deact_q;
    logic [2:0]               bit_sel_q;
    logic [2:0]               out_sel_q;
    logic [8*NUM_BYTES-1:0]   result_q;
    logic                     valid_q;
    logic                     busy_q;

    // Sequencer: state, phase counters and every registered output advance together,
    // so each output already holds the value that belongs to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            delay_q   <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            act_q     <= 1'b0;
            deact_q   <= 1'b0;
            bit_sel_q <= '0;
            out_sel_q <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Configuration is captured once so the host may change it mid-run.
                    if (start) begin
                        delay_q   <= delay_cfg;
                        bit_sel_q <= bit_sel_cfg;
                        act_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_ARM;
                    end
                end

                S_ARM: begin
                    act_q <= 1'b0;
                    if (delay_q == 8'd0) begin
                        // Zero gap: deactivate lands on the cycle right after activate.
                        deact_q <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q   <= CNT_W'(delay_q) - CNT_ONE;
                        state_q <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (cnt_q == '0) begin
                        deact_q <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_STOP: begin
                    deact_q <= 1'b0;
                    cnt_q   <= SETTLE_LAST;
                    state_q <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        out_sel_q <= '0;
                        wait_q    <= WAIT_LOAD;
                        state_q   <= S_READ;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_READ: begin
                    // tdc_byte follows out_sel combinationally; it is taken on the last
                    // cycle of each hold window so the core output has had time to settle.
                    if (wait_q == '0) begin
                        for (int k = 0; k < NUM_BYTES; k++) begin
                            if (out_sel_q == 3'(k)) begin
                                result_q[8*k +: 8] <= tdc_byte;
                            end
                        end
                        if (out_sel_q == LAST_BYTE) begin
                            out_sel_q <= '0;
                            valid_q   <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            out_sel_q <= out_sel_q + 3'd1;
                            wait_q    <= WAIT_LOAD;
                        end
                    end else begin
                        wait_q <= wait_q - WAIT_ONE;
                    end
                end

                S_DONE: begin
                    // result is left untouched after the handshake; only the next
                    // READ overwrites it.
                    if (result_ready) begin
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        bit_sel_q <= '0;
                        state_q   <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ro_activate   = act_q;
    assign ro_deactivate = deact_q;
    assign bit_sel       = bit_sel_q;
    assign out_sel       = out_sel_q;
    assign result        = result_q;
    assign result_valid  = valid_q;
    assign busy          = busy_q;

endmodule
